// File: rtl/uart_tx_parity.sv
// UART transmitter: start / DATA_WIDTH data bits (LSB first) / optional odd parity / stop.
// Bit timing comes from an internal divider of CLKS_PER_BIT clocks per serial bit.
module uart_tx_parity #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  parity_out
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  baud_last;

  assign baud_last = (baud_cnt == CNT_LAST);
  assign idx_nxt   = bit_idx + 1'b1;

  // Every output is loaded one edge ahead of the state it belongs to, so the
  // line level is always a flop and changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == S_IDLE) begin
        baud_cnt <= '0;
        tx_out   <= 1'b1;
        if (tx_start) begin
          data_q     <= tx_data;
          parity_out <= ~^tx_data;
          state      <= S_START;
          tx_out     <= 1'b0;
          tx_busy    <= 1'b1;
        end
      end else begin
        baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          case (state)
            S_START: begin
              state   <= S_DATA;
              bit_idx <= '0;
              tx_out  <= data_q[0];
            end
            S_DATA: begin
              if (bit_idx == IDX_LAST) begin
                if (PARITY_EN != 0) begin
                  state  <= S_PARITY;
                  tx_out <= parity_out;
                end else begin
                  state  <= S_STOP;
                  tx_out <= 1'b1;
                end
              end else begin
                bit_idx <= idx_nxt;
                tx_out  <= data_q[idx_nxt];
              end
            end
            S_PARITY: begin
              state  <= S_STOP;
              tx_out <= 1'b1;
            end
            S_STOP: begin
              state   <= S_IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end
            default: begin
              state  <= S_IDLE;
              tx_out <= 1'b1;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_parity.sv
// Scoreboard bench for uart_tx_parity: stimulus pushes expected frames, a line
// monitor decodes tx_out and pops/compares each completed frame.
module tb_uart_tx_parity;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FRAME = (DW + 3) * CPB;  // 44 cycles with parity

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    int            gap;   // required cycles from previous tx_done to start, -1 = any
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_out, tx_busy, tx_done, parity_out;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q[$];

  uart_tx_parity #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done), .parity_out(parity_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic p, input int gap);
    exp_t e;
    e.data = d; e.par = p; e.gap = gap;
    return e;
  endfunction

  // Line monitor: offset 0 is the first start-bit cycle; bits sampled mid-bit.
  initial begin
    int st, last_done;
    logic [10:0] bits;
    bit abort, done_early, busy_bad, done_at, busy_at, par_at;
    exp_t e;
    last_done = -1000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || tx_out !== 1'b0) continue;
      st = cyc; abort = 0; done_early = 0; busy_bad = 0; bits = '0;
      done_at = 0; busy_at = 1; par_at = 0;
      for (int o = 0; o <= FRAME; o++) begin
        if (o > 0) @(negedge clk);
        if (rst === 1'b1) begin abort = 1; break; end
        if (o < FRAME) begin
          if (o % CPB == CPB / 2) bits[o / CPB] = tx_out;
          if (tx_done !== 1'b0) done_early = 1;
          if (tx_busy !== 1'b1) busy_bad = 1;
        end else begin
          done_at = tx_done; busy_at = tx_busy; par_at = parity_out;
        end
      end
      if (abort) continue;
      if (q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        continue;
      end
      e = q.pop_front();
      chk("start_bit", int'(bits[0]), 0);
      chk("data_bits", int'(bits[8:1]), int'(e.data));
      chk("parity_bit", int'(bits[9]), int'(e.par));
      chk("stop_bit", int'(bits[10]), 1);
      chk("parity_out", int'(par_at), int'(e.par));
      chk("done_early", int'(done_early), 0);
      chk("done_at_44", int'(done_at), 1);
      chk("busy_in_frame", int'(busy_bad), 0);
      chk("busy_clear", int'(busy_at), 0);
      if (e.gap >= 0) chk("interframe_gap", st - last_done, e.gap);
      last_done = st + FRAME;
    end
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk({name, "_timeout"}, 1, 0);
  endtask

  // Single frame from idle; checks accept-to-done latency.
  task automatic send(input logic [DW-1:0] d, input logic p);
    int n;
    q.push_back(mk(d, p, -1));
    @(negedge clk); tx_data = d; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    wait_done("send", n);
    chk("latency", n, FRAME);
    @(negedge clk);
  endtask

  initial begin
    int n, hi;
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'hA5;
    // Reset wins over tx_start
    repeat (3) @(negedge clk);
    chk("rst_tx_out", int'(tx_out), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_parity_out", int'(parity_out), 0);
    rst = 1'b0; tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_line", int'(tx_out), 1);

    // Single frames and parity values
    send(8'hA5, 1'b1);
    send(8'h01, 1'b0);
    send(8'hFF, 1'b1);

    // Busy protect: request mid-frame is dropped, not queued
    q.push_back(mk(8'hA5, 1'b1, -1));
    @(negedge clk); tx_data = 8'hA5; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    repeat (10) @(negedge clk);
    tx_data = 8'h3C; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    wait_done("busy", n);
    hi = 0;
    repeat (60) begin @(negedge clk); if (tx_out === 1'b1 && tx_busy === 1'b0) hi++; end
    chk("no_second_frame", hi, 60);

    // Back-to-back with tx_start held; data change mid-frame has no effect
    q.push_back(mk(8'h55, 1'b1, -1));
    q.push_back(mk(8'hAA, 1'b1, 1));
    @(negedge clk); tx_data = 8'h55; tx_start = 1'b1;
    @(negedge clk);
    chk("b2b_busy1", int'(tx_busy), 1);
    tx_data = 8'hAA;
    wait_done("b2b_first", n);
    @(negedge clk);
    chk("b2b_busy2", int'(tx_busy), 1);
    tx_start = 1'b0; tx_data = 8'h00;
    wait_done("b2b_second", n);
    @(negedge clk);
    repeat (5) @(negedge clk);

    // Reset mid-DATA bit 3 (bit 3 of F0 is 0, so the line is low before reset)
    @(negedge clk); tx_data = 8'hF0; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;        // offset 0
    repeat (17) @(negedge clk);             // offset 17, inside bit 3
    chk("pre_rst_line", int'(tx_out), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx_out", int'(tx_out), 1);
    chk("abort_busy", int'(tx_busy), 0);
    @(negedge clk); rst = 1'b0;
    hi = 0;
    repeat (50) begin @(negedge clk); if (tx_done === 1'b1 || tx_out !== 1'b1) hi++; end
    chk("abort_no_done", hi, 0);
    send(8'h3C, 1'b1);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end
endmodule
